sync_fifo_fwft_ctrl: RTL and testbench
======================================

Name: sync_fifo_fwft_ctrl

Overview:
- Next-generation synchronous FIFO with its storage built in (simple dual-port array, registered read).
- One parameter selects first-word-fall-through (FWFT) or standard read mode.
- Usable depth is the full 2^AWIDTH entries.
- Adds runtime-programmable almost-full/almost-empty thresholds, write/read protection at full/empty, an exact occupancy count, and sticky, clearable error flags. Used as the general buffering primitive in datapaths.

Parameters:
- DWIDTH, 8, data width in bits.
- AWIDTH, 8, address width; DEPTH = 2^AWIDTH entries.
- FWFT, 1, 1 = first-word-fall-through read; 0 = standard read with 1-cycle read latency.
- U_DLY, 1, simulation delay on registered assignments.

Ports:
- i_clk_sys  in  1  system clock; all logic on its rising edge.
- i_rst_n  in  1  synchronous active-low reset.
- i_wen  in  1  write request.
- i_wdata  in  DWIDTH  write data.
- i_ren  in  1  read request (FWFT: acknowledge of the current o_rdata).
- o_rdata  out  DWIDTH  read data.
- o_rvalid  out  1  o_rdata valid (FWFT: equals ~o_empty; standard: one-cycle pulse per accepted read).
- i_alfull_th  in  AWIDTH+1  almost-full threshold.
- i_alempty_th  in  AWIDTH+1  almost-empty threshold.
- i_err_clr  in  1  clears the sticky error flags.
- o_full, o_alfull, o_empty, o_alempty  out  1 each  status flags.
- o_cnt  out  AWIDTH+1  occupancy, 0..DEPTH.
- o_overflow, o_underflow  out  1 each  sticky error flags.

Behaviour:
- Reset (sampled on the clock edge while i_rst_n=0):
  - Pointers and count go to 0; contents are discarded.
  - o_empty=1, o_alempty=1; all other outputs 0, including o_rdata and o_rvalid.
  - A reset mid-operation aborts any in-flight prefetch or read. No data survives.
- Write accept: wacc = i_wen & ~o_full. Data is stored at the write pointer, which then increments and wraps at DEPTH.
- Read accept: racc = i_ren & ~o_empty.
- Protection:
  - i_wen with o_full=1: write dropped, o_overflow sets.
  - i_ren with o_empty=1: no pointer change, o_underflow sets.
  - Both errors stay set until i_err_clr. If a set and i_err_clr occur in the same cycle, set wins.
- o_cnt:
  - Next value = o_cnt + wacc - racc.
  - Simultaneous wacc and racc leaves the count unchanged.
  - Count includes words already prefetched into the FWFT output stage.
- Flags are registered, each derived from the next count:
  - o_full = (cnt_next == DEPTH).
  - o_alfull = (cnt_next >= i_alfull_th).
  - o_alempty = (cnt_next <= i_alempty_th).
  - Standard mode: o_empty = (cnt_next == 0).
  - FWFT mode: o_empty = ~(output stage holds valid data).
- At full, a simultaneous read and write accepts the read and rejects the write, because o_full is the registered value. At empty, a simultaneous read and write accepts the write and rejects the read.
- Standard mode:
  - Write accepted at edge k gives o_empty=0 after edge k+1.
  - Read accepted at edge m gives o_rdata valid and o_rvalid=1 for one cycle after edge m+1.
  - o_rdata holds its value otherwise.
- FWFT mode:
  - Write into an empty FIFO accepted at edge k gives o_empty=0 with o_rdata valid after edge k+2.
  - o_rdata changes only after racc, or on the first fill.
  - Sustained one read per cycle with no bubbles while stored data remains. The read stage is a 2-entry prefetch (RAM read register plus output register) to allow this.
- Wrap-around: pointers are AWIDTH bits and wrap naturally; full/empty are decided from o_cnt, never from pointer equality.
- Threshold ports may change at any time; the flags follow from the next edge.

Decomposition:
- Shared header fifo_defs.vh holds the FIFO_MODE_STD=0 / FIFO_MODE_FWFT=1 encodings.
- DEPTH and CNT_W=AWIDTH+1 are localparams of the block.
- One sub-module, sync_fifo_ram:
  - simple dual-port, DWIDTH x 2^AWIDTH;
  - write port: wen, waddr, wdata;
  - read port: ren, raddr, registered rdata.
- The prefetch/output logic stays in the top module.

Test Plan:
- FWFT=1, AWIDTH=4: write 0x01..0x10 back-to-back, then read continuously → o_full=1 and o_cnt=16 after the 16th write; reads return 0x01..0x10 in order with no bubble; o_empty=1 after the last read.
- FWFT=1, single write 0xA5 into empty at edge k → o_empty=0 and o_rdata=0xA5 after edge k+2; o_cnt=1 after edge k+1.
- FWFT=0: write 0x11, 0x22, then i_ren at edge m → o_rvalid pulses with 0x11 after edge m+1, no valid otherwise; o_cnt 2→1.
- Full with simultaneous i_wen and i_ren → read accepted, write dropped, o_cnt 16→15, o_overflow=1. Next, i_wen into full with no read → o_overflow stays 1. i_err_clr → 0.
- Empty with i_ren → o_underflow=1, o_cnt=0. Then i_alfull_th=12, i_alempty_th=3 and fill → o_alempty clears on o_cnt=4, o_alfull sets on o_cnt=12.
- Reset asserted with o_cnt=9 mid-stream → next cycle o_cnt=0, o_empty=1, o_alempty=1, o_rdata=0, error flags 0; a subsequent write/read round-trip returns the new data only.

Source files
------------

// File: rtl/sync_fifo_fwft_ctrl_pkg.sv
// Shared definitions for the synchronous FIFO controller.
// Read-mode encodings selected by the FWFT parameter.
package sync_fifo_fwft_ctrl_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage array with a registered read port.
// Array contents are never reset; only the read register is.
module sync_fifo_ram #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wen,
    input  logic [AWIDTH-1:0] waddr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic              ren,
    input  logic [AWIDTH-1:0] raddr,
    output logic [DWIDTH-1:0] rdata
);

    logic [DWIDTH-1:0] mem [2**AWIDTH];

    always_ff @(posedge clk) begin
        if (wen) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (ren) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sync_fifo_fwft_ctrl.sv
// Synchronous FIFO with built-in storage, FWFT or standard read mode,
// programmable almost flags, exact occupancy and sticky error flags.
module sync_fifo_fwft_ctrl #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 8,
    parameter int FWFT   = 1
) (
    input  logic              i_clk_sys,
    input  logic              i_rst_n,
    input  logic              i_wen,
    input  logic [DWIDTH-1:0] i_wdata,
    input  logic              i_ren,
    output logic [DWIDTH-1:0] o_rdata,
    output logic              o_rvalid,
    input  logic [AWIDTH:0]   i_alfull_th,
    input  logic [AWIDTH:0]   i_alempty_th,
    input  logic              i_err_clr,
    output logic              o_full,
    output logic              o_alfull,
    output logic              o_empty,
    output logic              o_alempty,
    output logic [AWIDTH:0]   o_cnt,
    output logic              o_overflow,
    output logic              o_underflow
);

    import sync_fifo_fwft_ctrl_pkg::*;

    localparam int DEPTH   = 2**AWIDTH;
    localparam int CNT_W   = AWIDTH + 1;
    localparam bit IS_FWFT = (FWFT == FIFO_MODE_FWFT);

    logic [AWIDTH-1:0] wptr;
    logic [AWIDTH-1:0] rptr;
    logic [DWIDTH-1:0] ram_rdata;
    logic [DWIDTH-1:0] b_data;
    logic              a_valid;
    logic              b_valid;
    logic              rvalid_q;

    logic              wacc;
    logic              racc;
    logic              pop_a;
    logic              pop_b;
    logic              move_ab;
    logic              a_free;
    logic              fetch;
    logic              ram_ren;
    logic              a_valid_n;
    logic              b_valid_n;
    logic              empty_n;
    logic [CNT_W-1:0]  cnt_next;
    logic [CNT_W-1:0]  stage_cnt;

    // Stage A is the RAM read register, stage B the output register.
    // When both hold data, B is the head and A the next word.
    always_comb begin
        wacc      = i_wen & ~o_full;
        racc      = i_ren & ~o_empty;
        cnt_next  = o_cnt + CNT_W'(wacc) - CNT_W'(racc);
        pop_b     = racc & b_valid;
        pop_a     = racc & ~b_valid;
        move_ab   = a_valid & ~pop_a & (~b_valid | pop_b);
        a_free    = ~a_valid | pop_a | move_ab;
        stage_cnt = CNT_W'(a_valid) + CNT_W'(b_valid);
        fetch     = IS_FWFT & a_free & (o_cnt != stage_cnt);
        a_valid_n = fetch | (a_valid & ~a_free);
        b_valid_n = move_ab | (b_valid & ~pop_b);
        ram_ren   = IS_FWFT ? fetch : racc;
        empty_n   = IS_FWFT ? ~(a_valid_n | b_valid_n)
                            : (cnt_next == '0);
    end

    sync_fifo_ram #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH)
    ) u_ram (
        .clk   (i_clk_sys),
        .rst_n (i_rst_n),
        .wen   (wacc & i_rst_n),
        .waddr (wptr),
        .wdata (i_wdata),
        .ren   (ram_ren),
        .raddr (rptr),
        .rdata (ram_rdata)
    );

    always_ff @(posedge i_clk_sys) begin
        if (!i_rst_n) begin
            wptr        <= '0;
            rptr        <= '0;
            o_cnt       <= '0;
            a_valid     <= 1'b0;
            b_valid     <= 1'b0;
            b_data      <= '0;
            rvalid_q    <= 1'b0;
            o_full      <= 1'b0;
            o_alfull    <= 1'b0;
            o_empty     <= 1'b1;
            o_alempty   <= 1'b1;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            if (wacc) begin
                wptr <= wptr + AWIDTH'(1);
            end
            if (ram_ren) begin
                rptr <= rptr + AWIDTH'(1);
            end
            if (move_ab) begin
                b_data <= ram_rdata;
            end
            o_cnt       <= cnt_next;
            a_valid     <= a_valid_n;
            b_valid     <= b_valid_n;
            rvalid_q    <= racc;
            o_full      <= (cnt_next == CNT_W'(DEPTH));
            o_alfull    <= (cnt_next >= i_alfull_th);
            o_alempty   <= (cnt_next <= i_alempty_th);
            o_empty     <= empty_n;
            // A new error in the clearing cycle keeps the flag set.
            o_overflow  <= (i_wen & o_full)
                         | (o_overflow & ~i_err_clr);
            o_underflow <= (i_ren & o_empty)
                         | (o_underflow & ~i_err_clr);
        end
    end

    always_comb begin
        o_rdata  = (IS_FWFT & b_valid) ? b_data : ram_rdata;
        o_rvalid = IS_FWFT ? ~o_empty : rvalid_q;
    end

endmodule

// File: tb/tb_sync_fifo_fwft_ctrl.sv
// Directed bench: one FWFT and one standard-mode FIFO share stimulus,
// each checked against hand-computed values.
module tb_sync_fifo_fwft_ctrl;

    logic       clk;
    logic       rst_n;
    logic       wen;
    logic       ren;
    logic       err_clr;
    logic [7:0] wdata;
    logic [4:0] alfull_th;
    logic [4:0] alempty_th;

    logic [7:0] f_rdata, s_rdata;
    logic       f_rvalid, s_rvalid;
    logic       f_full, s_full;
    logic       f_alfull, s_alfull;
    logic       f_empty, s_empty;
    logic       f_alempty, s_alempty;
    logic [4:0] f_cnt, s_cnt;
    logic       f_ovf, s_ovf;
    logic       f_udf, s_udf;

    int checks = 0;
    int errors = 0;

    sync_fifo_fwft_ctrl #(.DWIDTH(8), .AWIDTH(4), .FWFT(1)) dut_f (
        .i_clk_sys    (clk),
        .i_rst_n      (rst_n),
        .i_wen        (wen),
        .i_wdata      (wdata),
        .i_ren        (ren),
        .o_rdata      (f_rdata),
        .o_rvalid     (f_rvalid),
        .i_alfull_th  (alfull_th),
        .i_alempty_th (alempty_th),
        .i_err_clr    (err_clr),
        .o_full       (f_full),
        .o_alfull     (f_alfull),
        .o_empty      (f_empty),
        .o_alempty    (f_alempty),
        .o_cnt        (f_cnt),
        .o_overflow   (f_ovf),
        .o_underflow  (f_udf)
    );

    sync_fifo_fwft_ctrl #(.DWIDTH(8), .AWIDTH(4), .FWFT(0)) dut_s (
        .i_clk_sys    (clk),
        .i_rst_n      (rst_n),
        .i_wen        (wen),
        .i_wdata      (wdata),
        .i_ren        (ren),
        .o_rdata      (s_rdata),
        .o_rvalid     (s_rvalid),
        .i_alfull_th  (alfull_th),
        .i_alempty_th (alempty_th),
        .i_err_clr    (err_clr),
        .o_full       (s_full),
        .o_alfull     (s_alfull),
        .o_empty      (s_empty),
        .o_alempty    (s_alempty),
        .o_cnt        (s_cnt),
        .o_overflow   (s_ovf),
        .o_underflow  (s_udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        wen        = 1'b0;
        ren        = 1'b0;
        err_clr    = 1'b0;
        wdata      = 8'h00;
        alfull_th  = 5'd14;
        alempty_th = 5'd1;
        tick();
        tick();
        rst_n = 1'b1;

        chk("rst_f_cnt", f_cnt, 0);
        chk("rst_f_empty", f_empty, 1);
        chk("rst_f_alempty", f_alempty, 1);
        chk("rst_f_full", f_full, 0);
        chk("rst_f_alfull", f_alfull, 0);
        chk("rst_f_rdata", f_rdata, 0);
        chk("rst_f_rvalid", f_rvalid, 0);
        chk("rst_f_ovf", f_ovf, 0);
        chk("rst_f_udf", f_udf, 0);
        chk("rst_s_empty", s_empty, 1);
        chk("rst_s_rvalid", s_rvalid, 0);
        chk("rst_s_rdata", s_rdata, 0);

        // single write into empty FWFT
        wen = 1'b1; wdata = 8'hA5;
        tick();
        wen = 1'b0;
        chk("a_f_cnt_k1", f_cnt, 1);
        chk("a_f_empty_k1", f_empty, 1);
        chk("a_s_empty_k1", s_empty, 0);
        chk("a_s_cnt_k1", s_cnt, 1);
        tick();
        chk("a_f_empty_k2", f_empty, 0);
        chk("a_f_rdata_k2", f_rdata, 8'hA5);
        chk("a_f_rvalid_k2", f_rvalid, 1);
        chk("a_s_rvalid_idle", s_rvalid, 0);
        tick();
        chk("a_f_rdata_hold", f_rdata, 8'hA5);
        ren = 1'b1;
        tick();
        ren = 1'b0;
        chk("a_f_cnt_rd", f_cnt, 0);
        chk("a_f_empty_rd", f_empty, 1);
        chk("a_s_rvalid_rd", s_rvalid, 1);
        chk("a_s_rdata_rd", s_rdata, 8'hA5);
        chk("a_s_cnt_rd", s_cnt, 0);
        tick();
        chk("a_s_rvalid_off", s_rvalid, 0);
        chk("a_s_rdata_hold", s_rdata, 8'hA5);

        // standard read latency
        wen = 1'b1; wdata = 8'h11;
        tick();
        wdata = 8'h22;
        tick();
        wen = 1'b0;
        chk("b_s_cnt2", s_cnt, 2);
        chk("b_s_rvalid_pre", s_rvalid, 0);
        ren = 1'b1;
        tick();
        ren = 1'b0;
        chk("b_s_rvalid", s_rvalid, 1);
        chk("b_s_rdata", s_rdata, 8'h11);
        chk("b_s_cnt1", s_cnt, 1);
        chk("b_f_rdata", f_rdata, 8'h22);
        chk("b_f_cnt1", f_cnt, 1);
        tick();
        chk("b_s_rvalid_off", s_rvalid, 0);
        chk("b_s_rdata_hold", s_rdata, 8'h11);
        chk("b_f_rdata_hold", f_rdata, 8'h22);
        ren = 1'b1;
        tick();
        ren = 1'b0;
        chk("b_f_empty", f_empty, 1);
        chk("b_f_cnt0", f_cnt, 0);
        chk("b_s_rdata2", s_rdata, 8'h22);
        chk("b_s_rvalid2", s_rvalid, 1);
        chk("b_s_empty", s_empty, 1);
        tick();

        // fill to full
        for (int i = 1; i <= 16; i++) begin
            wen = 1'b1; wdata = 8'(i);
            tick();
        end
        wen = 1'b0;
        chk("c_f_cnt16", f_cnt, 16);
        chk("c_f_full", f_full, 1);
        chk("c_s_full", s_full, 1);
        chk("c_f_head", f_rdata, 8'h01);

        // read and write together at full
        wen = 1'b1; wdata = 8'hEE; ren = 1'b1;
        tick();
        wen = 1'b0; ren = 1'b0;
        chk("d_f_cnt15", f_cnt, 15);
        chk("d_f_full", f_full, 0);
        chk("d_f_ovf", f_ovf, 1);
        chk("d_f_rdata", f_rdata, 8'h02);
        chk("d_s_rdata", s_rdata, 8'h01);
        chk("d_s_rvalid", s_rvalid, 1);
        chk("d_s_ovf", s_ovf, 1);
        chk("d_s_cnt15", s_cnt, 15);
        wen = 1'b1; wdata = 8'h11;
        tick();
        chk("d_f_refull", f_full, 1);
        chk("d_f_cnt16", f_cnt, 16);
        wdata = 8'h12;
        tick();
        chk("d_f_ovf_hold", f_ovf, 1);
        chk("d_f_cnt_drop", f_cnt, 16);
        wdata = 8'h13; err_clr = 1'b1;
        tick();
        wen = 1'b0;
        chk("d_f_ovf_setwins", f_ovf, 1);
        tick();
        err_clr = 1'b0;
        chk("d_f_ovf_clr", f_ovf, 0);
        chk("d_s_ovf_clr", s_ovf, 0);

        // continuous drain with no bubble
        for (int v = 2; v <= 17; v++) begin
            chk("e_f_stream", f_rdata, 32'(v));
            chk("e_f_nobubble", f_empty, 0);
            ren = 1'b1;
            tick();
            chk("e_s_rvalid", s_rvalid, 1);
            chk("e_s_stream", s_rdata, 32'(v));
        end
        ren = 1'b0;
        chk("e_f_empty", f_empty, 1);
        chk("e_f_cnt0", f_cnt, 0);
        chk("e_s_cnt0", s_cnt, 0);

        // underflow
        ren = 1'b1;
        tick();
        ren = 1'b0;
        chk("u_f_udf", f_udf, 1);
        chk("u_s_udf", s_udf, 1);
        chk("u_f_cnt0", f_cnt, 0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("u_f_udf_clr", f_udf, 0);
        chk("u_s_udf_clr", s_udf, 0);

        // thresholds
        alfull_th = 5'd12; alempty_th = 5'd3;
        tick();
        chk("t_f_alempty0", f_alempty, 1);
        chk("t_f_alfull0", f_alfull, 0);
        for (int i = 1; i <= 12; i++) begin
            wen = 1'b1; wdata = 8'(8'h40 + i);
            tick();
            chk("t_f_cnt", f_cnt, 32'(i));
            chk("t_f_alempty", f_alempty, 32'(i <= 3));
            chk("t_f_alfull", f_alfull, 32'(i >= 12));
            chk("t_s_alfull", s_alfull, 32'(i >= 12));
        end
        wen = 1'b0;
        ren = 1'b1;
        tick();
        tick();
        tick();
        ren = 1'b0;
        chk("r_f_cnt9", f_cnt, 9);
        chk("r_s_cnt9", s_cnt, 9);

        // reset mid-stream, write during reset ignored
        rst_n = 1'b0; wen = 1'b1; wdata = 8'h77;
        tick();
        rst_n = 1'b1; wen = 1'b0;
        chk("r_f_cnt", f_cnt, 0);
        chk("r_f_empty", f_empty, 1);
        chk("r_f_alempty", f_alempty, 1);
        chk("r_f_rdata", f_rdata, 0);
        chk("r_f_ovf", f_ovf, 0);
        chk("r_f_udf", f_udf, 0);
        chk("r_s_rdata", s_rdata, 0);
        chk("r_s_cnt", s_cnt, 0);

        wen = 1'b1; wdata = 8'h3C;
        tick();
        wen = 1'b0;
        tick();
        chk("r_f_rt_empty", f_empty, 0);
        chk("r_f_rt_rdata", f_rdata, 8'h3C);
        chk("r_f_rt_cnt", f_cnt, 1);
        ren = 1'b1;
        tick();
        ren = 1'b0;
        chk("r_s_rt_rvalid", s_rvalid, 1);
        chk("r_s_rt_rdata", s_rdata, 8'h3C);
        chk("r_f_rt_cnt0", f_cnt, 0);
        chk("r_f_rt_empty1", f_empty, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
